// File: rtl/sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sub_pipe
// Purpose  : Two-stage valid/ready pipelined subtractor (a - b) that reports
//            the unsigned borrow and the signed overflow of the difference.
// Revision : 1.0 - initial release
// ============================================================================
module sub_pipe #(
  parameter int WIDTH = 16  // must be even and >= 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_ovf
);

  localparam int HALF = WIDTH / 2;

  logic            s1_valid_q,  s1_valid_d;
  logic [HALF-1:0] s1_lo_q,     s1_lo_d;
  logic            s1_borrow_q, s1_borrow_d;
  logic [HALF-1:0] s1_a_hi_q,   s1_a_hi_d;
  logic [HALF-1:0] s1_b_hi_q,   s1_b_hi_d;

  logic             s2_valid_q,  s2_valid_d;
  logic [WIDTH-1:0] s2_diff_q,   s2_diff_d;
  logic             s2_borrow_q, s2_borrow_d;
  logic             s2_ovf_q,    s2_ovf_d;

  logic            accept;
  logic            s2_load;
  logic            s2_pop;
  logic [HALF:0]   lo_sub;
  logic [HALF:0]   hi_sub;

  always_comb begin
    in_ready = !s1_valid_q || !s2_valid_q || out_ready;
    accept   = in_valid && in_ready;
    s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    s2_pop   = s2_valid_q && out_ready;
  end

  // The extra top bit of each half-width subtraction is that half's borrow.
  always_comb begin
    lo_sub = {1'b0, in_a[HALF-1:0]} - {1'b0, in_b[HALF-1:0]};
    hi_sub = {1'b0, s1_a_hi_q} - {1'b0, s1_b_hi_q} - {{HALF{1'b0}}, s1_borrow_q};
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_lo_d     = s1_lo_q;
    s1_borrow_d = s1_borrow_q;
    s1_a_hi_d   = s1_a_hi_q;
    s1_b_hi_d   = s1_b_hi_q;
    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_lo_d     = lo_sub[HALF-1:0];
      s1_borrow_d = lo_sub[HALF];
      s1_a_hi_d   = in_a[WIDTH-1:HALF];
      s1_b_hi_d   = in_b[WIDTH-1:HALF];
    end else if (s2_load) begin
      s1_valid_d  = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_diff_d   = s2_diff_q;
    s2_borrow_d = s2_borrow_q;
    s2_ovf_d    = s2_ovf_q;
    if (s2_load) begin
      s2_valid_d  = 1'b1;
      s2_diff_d   = {hi_sub[HALF-1:0], s1_lo_q};
      s2_borrow_d = hi_sub[HALF];
      s2_ovf_d    = (s1_a_hi_q[HALF-1] != s1_b_hi_q[HALF-1]) &&
                    (hi_sub[HALF-1] != s1_a_hi_q[HALF-1]);
    end else if (s2_pop) begin
      s2_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_borrow_q <= 1'b0;
      s1_a_hi_q   <= '0;
      s1_b_hi_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_diff_q   <= '0;
      s2_borrow_q <= 1'b0;
      s2_ovf_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_borrow_q <= s1_borrow_d;
      s1_a_hi_q   <= s1_a_hi_d;
      s1_b_hi_q   <= s1_b_hi_d;
      s2_valid_q  <= s2_valid_d;
      s2_diff_q   <= s2_diff_d;
      s2_borrow_q <= s2_borrow_d;
      s2_ovf_q    <= s2_ovf_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_diff   = s2_diff_q;
  assign out_borrow = s2_borrow_q;
  assign out_ovf    = s2_ovf_q;

endmodule
`default_nettype wire

// File: doc/sub_pipe.md
SUB_PIPE -- requirements
Module: sub_pipe

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width; it SHALL be even and >= 4.
REQ-002 Port: clock  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; asserting it (0) SHALL clear state immediately, independent of clock.
REQ-004 Port: in_valid  input  1  in_a/in_b carry an operand pair this cycle.
REQ-005 Port: in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 Port: in_a  input  WIDTH  minuend.
REQ-007 Port: in_b  input  WIDTH  subtrahend.
REQ-008 Port: out_valid  output  1  out_diff/out_borrow/out_ovf hold a result.
REQ-009 Port: out_ready  input  1  downstream accepts the result this cycle.
REQ-010 Port: out_diff  output  WIDTH  (in_a - in_b) mod 2^WIDTH.
REQ-011 Port: out_borrow  output  1  unsigned borrow; 1 iff in_a < in_b (unsigned).
REQ-012 Port: out_ovf  output  1  signed overflow of two's-complement in_a - in_b.

Function
REQ-013 Transfer at the input SHALL occur when in_valid and in_ready are both 1 on a rising edge; at the output, when out_valid and out_ready are both 1.
REQ-014 Two pipeline stages, S1 and S2, each with a valid bit, SHALL implement the subtraction.
REQ-015 S1 contents on accept:
- low half: in_a[WIDTH/2-1:0] - in_b[WIDTH/2-1:0];
- the low-half borrow;
- the unmodified high halves of in_a and in_b.
REQ-016 S2 contents on S1->S2 advance: high half computed as a_hi - b_hi - low_borrow; stored with the S1 low half, final borrow and overflow.
REQ-017 out_ovf SHALL be 1 iff sign(a) != sign(b) and sign(diff) != sign(a).
REQ-018 Outputs SHALL be driven directly from S2 registers; no combinational path from in_a/in_b to any output.
REQ-019 Stage advance conditions:
- S2 SHALL load when S1 is valid and (S2 is empty or out_ready=1);
- S2 SHALL clear its valid bit when it transfers out and S1 is empty.
REQ-020 in_ready SHALL equal (!S1.valid) | (!S2.valid) | out_ready; it is combinational from out_ready and stage valids only.
REQ-021 Latency: an accepted pair SHALL appear at the output exactly 2 cycles after acceptance when unstalled.
REQ-022 Throughput: one result per cycle SHALL be sustained while out_ready=1.
REQ-023 Backpressure:
- with out_ready=0, at most 2 pairs SHALL be held;
- in_ready SHALL go 0 when both stages are valid;
- no accepted pair SHALL be lost, duplicated or reordered.
REQ-024 While out_valid=1 and out_ready=0, out_diff, out_borrow and out_ovf SHALL remain stable.
REQ-025 Simultaneous output transfer and input accept in the same cycle SHALL both complete with no bubble.
REQ-026 Wrap-around: results SHALL be modulo 2^WIDTH with no saturation (e.g. 0 - 1 = all ones).
REQ-027 in_a/in_b SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-028 While reset=0, S1.valid, S2.valid and out_valid SHALL be 0, and out_diff, out_borrow and out_ovf SHALL be 0.
REQ-029 While reset=0, in_ready SHALL be 1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight pairs; no result SHALL be presented after release.
REQ-031 After release, the first accept SHALL occur on the first rising edge at which reset=1 and in_valid=1.

Verification
REQ-032 in_a=0x0005, in_b=0x0003, out_ready=1 -> 2 cycles later: out_valid=1, out_diff=0x0002, borrow=0, ovf=0.
REQ-033 in_a=0x0000, in_b=0x0001 -> out_diff=0xFFFF, borrow=1, ovf=0.
REQ-034 Overflow and cross-half borrow cases:
- in_a=0x8000, in_b=0x0001 -> out_diff=0x7FFF, borrow=0, ovf=1;
- in_a=0x0100, in_b=0x0001 -> out_diff=0x00FF, borrow=0, ovf=0 (borrow crosses halves).
REQ-035 Backpressure: 4 back-to-back pairs (10-1, 20-2, 30-3, 40-4) with out_ready=0 for 4 cycles, then out_ready=1 ->
- in_ready=0 after 2 accepts;
- outputs 9, 18, 27, 36 in order, each exactly once.
REQ-036 Reset mid-stream: assert reset=0 with both stages valid -> out_valid=0 immediately (before the next edge), in_ready=1; after release with in_valid=0, out_valid stays 0.
